// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller CPU request path.
package intc_pkg;

    localparam int unsigned INTC_PRI_DW   = 4;
    localparam int unsigned INTC_VEC_W    = 8;
    localparam int unsigned INTC_ID_W     = 5;
    localparam int unsigned INTC_CNT_W    = 4;
    localparam int unsigned INTC_VEC_BASE = 64;

    typedef struct packed {
        logic                   req;
        logic [INTC_PRI_DW-1:0] pri;
        logic [INTC_VEC_W-1:0]  vec;
    } intc_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACKD = 2'd2
    } intc_req_st_e;

endpackage

// File: rtl/intc_guard_cnt.sv
// Loadable down-counter timing the post-acknowledge guard interval.
module intc_guard_cnt
    import intc_pkg::*;
#(
    parameter int unsigned CW = INTC_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Flags that the decrement taking effect this cycle lands on zero.
    assign o_zero = (r_cnt <= CW'(1));

endmodule

// File: rtl/intc_cpu_req.sv
// Qualifies the selector winner against the CPU mask, holds the request and
// runs the acknowledge / clear handshake toward one CPU.
module intc_cpu_req
    import intc_pkg::*;
#(
    parameter int unsigned DW     = 5,
    parameter int unsigned PRI_DW = INTC_PRI_DW,
    parameter int unsigned VEC_W  = INTC_VEC_W,
    parameter int unsigned GUARD  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW+VEC_W-1:0]   sel_i,
    input  logic [PRI_DW-1:0]     imask_i,
    input  logic                  int_ack_i,
    output logic                  int_req_o,
    output logic [PRI_DW-1:0]     int_lvl_o,
    output logic [VEC_W-1:0]      int_vec_o,
    output logic                  clr_o,
    output logic [INTC_ID_W-1:0]  clr_id_o,
    output logic                  busy_o
);

    intc_req_st_e          r_state;
    intc_req_st_e          w_state_nxt;
    intc_sel_t             r_sel_q;
    logic [PRI_DW-1:0]     r_hold_lvl;
    logic [VEC_W-1:0]      r_hold_vec;
    logic                  r_int_req;
    logic                  r_busy;
    logic                  r_clr;
    logic [INTC_ID_W-1:0]  r_clr_id;

    logic                  w_elig;
    logic                  w_hold_ld;
    logic                  w_cnt_ld;
    logic                  w_cnt_dec;
    logic                  w_cnt_zero;
    logic                  w_clr_nxt;
    logic [VEC_W-1:0]      w_vec_off;

    assign w_elig = r_sel_q.req && (r_sel_q.pri > imask_i);

    // Vector base is a multiple of 32, so the source id is the vector offset's low bits.
    assign w_vec_off = r_hold_vec - VEC_W'(INTC_VEC_BASE);

    intc_guard_cnt #(
        .CW (INTC_CNT_W)
    ) u_guard_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_ld),
        .i_load_val (INTC_CNT_W'(GUARD)),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_hold_ld   = 1'b0;
        w_cnt_ld    = 1'b0;
        w_cnt_dec   = 1'b0;
        w_clr_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig) begin
                    w_hold_ld   = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // Acknowledge beats both preemption and withdrawal.
                if (int_ack_i) begin
                    w_clr_nxt   = 1'b1;
                    w_cnt_ld    = 1'b1;
                    w_state_nxt = ACKD;
                end else if (w_elig && (r_sel_q.pri > r_hold_lvl)) begin
                    w_hold_ld   = 1'b1;
                end else if (!w_elig) begin
                    w_state_nxt = IDLE;
                end
            end
            ACKD: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sel_q    <= '0;
            r_hold_lvl <= '0;
            r_hold_vec <= '0;
            r_int_req  <= 1'b0;
            r_busy     <= 1'b0;
            r_clr      <= 1'b0;
            r_clr_id   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel_q   <= intc_sel_t'(sel_i);
            r_int_req <= (w_state_nxt == REQ);
            r_busy    <= (w_state_nxt != IDLE);
            r_clr     <= w_clr_nxt;
            r_clr_id  <= w_clr_nxt ? INTC_ID_W'(w_vec_off) : '0;
            if (w_hold_ld) begin
                r_hold_lvl <= r_sel_q.pri;
                r_hold_vec <= r_sel_q.vec;
            end
        end
    end

    assign int_req_o = r_int_req;
    assign int_lvl_o = r_hold_lvl;
    assign int_vec_o = r_hold_vec;
    assign clr_o     = r_clr;
    assign clr_id_o  = r_clr_id;
    assign busy_o    = r_busy;

endmodule

// File: tb/tb_intc_cpu_req.sv
// Randomized and directed bench for intc_cpu_req against a behavioural model.
module tb_intc_cpu_req;

    localparam int GUARD = 2;

    logic        clk;
    logic        rst;
    logic [12:0] sel_i;
    logic [3:0]  imask_i;
    logic        int_ack_i;
    logic        int_req_o;
    logic [3:0]  int_lvl_o;
    logic [7:0]  int_vec_o;
    logic        clr_o;
    logic [4:0]  clr_id_o;
    logic        busy_o;

    intc_cpu_req #(
        .DW     (5),
        .PRI_DW (4),
        .VEC_W  (8),
        .GUARD  (GUARD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel_i     (sel_i),
        .imask_i   (imask_i),
        .int_ack_i (int_ack_i),
        .int_req_o (int_req_o),
        .int_lvl_o (int_lvl_o),
        .int_vec_o (int_vec_o),
        .clr_o     (clr_o),
        .clr_id_o  (clr_id_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: a pending request, a guard countdown, and held level/vector.
    int m_selq    = 0;
    bit m_pending = 0;
    int m_guard   = 0;
    int m_lvl     = 0;
    int m_vec     = 0;
    bit m_clr     = 0;
    int m_clrid   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit r, input int s, input int m, input bit a);
        int  q_pri;
        int  q_vec;
        bit  elig;
        if (r) begin
            m_selq = 0; m_pending = 0; m_guard = 0;
            m_lvl = 0; m_vec = 0; m_clr = 0; m_clrid = 0;
            return;
        end
        q_pri = (m_selq / 256) % 16;
        q_vec = m_selq % 256;
        elig  = (m_selq >= 4096) && (q_pri > m)
;
        m_clr = 0;
        m_clrid = 0;
        if (m_pending) begin
            if (a) begin
                m_clr = 1; m_clrid = m_vec % 32;
                m_pending = 0; m_guard = GUARD;
            end else if (elig && q_pri > m_lvl) begin
                m_lvl = q_pri; m_vec = q_vec;
            end else if (!elig) begin
                m_pending = 0;
            end
        end else if (m_guard > 0) begin
            m_guard--;
        end else if (elig) begin
            m_pending = 1; m_lvl = q_pri; m_vec = q_vec;
        end
        m_selq = s;
    endtask

    task automatic step(input bit r, input logic [12:0] s, input logic [3:0] m, input bit a);
        rst = r; sel_i = s; imask_i = m; int_ack_i = a;
        @(posedge clk);
        model(r, int'(s), int'(m), a);
        #1;
        chk("req",   32'(int_req_o), 32'(m_pending));
        chk("lvl",   32'(int_lvl_o), 32'(m_lvl));
        chk("vec",   32'(int_vec_o), 32'(m_vec));
        chk("clr",   32'(clr_o),     32'(m_clr));
        chk("clrid", 32'(clr_id_o),  32'(m_clrid));
        chk("busy",  32'(busy_o),    32'(m_pending || (m_guard > 0)));
    endtask

    function automatic logic [12:0] mk(input bit q, input int p, input int v);
        return {q, 4'(p), 8'(v)};
    endfunction

    initial begin
        logic [12:0] s;
        logic [3:0]  m;
        rst = 1'b1; sel_i = '0; imask_i = '0; int_ack_i = 1'b0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_req", 32'(int_req_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_clr", 32'(clr_o), 0);

        // Basic request, ack, clear and guard spacing
        step(0, mk(1, 5, 70), 3, 0);
        chk("t1_lat", 32'(int_req_o), 0);
        step(0, mk(1, 5, 70), 3, 0);
        chk("t1_req", 32'(int_req_o), 1);
        chk("t1_lvl", 32'(int_lvl_o), 5);
        chk("t1_vec", 32'(int_vec_o), 70);
        step(0, mk(1, 5, 70), 3, 1);
        chk("t1_clr", 32'(clr_o), 1);
        chk("t1_clrid", 32'(clr_id_o), 6);
        chk("t1_drop", 32'(int_req_o), 0);
        step(0, mk(1, 5, 70), 3, 0);
        chk("t1_g1", 32'(int_req_o), 0);
        step(0, mk(1, 5, 70), 3, 0);
        chk("t1_g2", 32'(int_req_o), 0);
        step(0, mk(1, 5, 70), 3, 0);
        chk("t1_rereq", 32'(int_req_o), 1);

        // Mask boundary
        step(0, 0, 3, 0);
        step(0, 0, 3, 0);
        step(0, mk(1, 3, 33), 3, 0);
        step(0, mk(1, 3, 33), 3, 0);
        chk("t2_masked", 32'(int_req_o), 0);
        step(0, mk(1, 3, 33), 2, 0);
        chk("t2_req", 32'(int_req_o), 1);
        chk("t2_lvl", 32'(int_lvl_o), 3);

        // Preemption and hold
        step(0, mk(1, 5, 70), 2, 0);
        step(0, mk(1, 5, 70), 2, 0);
        chk("t3_pre1", 32'(int_lvl_o), 5);
        step(0, mk(1, 9, 88), 2, 0);
        step(0, mk(1, 9, 88), 2, 0);
        chk("t3_lvl", 32'(int_lvl_o), 9);
        chk("t3_vec", 32'(int_vec_o), 88);
        step(0, mk(1, 7, 99), 2, 0);
        step(0, mk(1, 7, 99), 2, 0);
        chk("t3_hold", 32'(int_vec_o), 88);
        chk("t3_req", 32'(int_req_o), 1);

        // Withdraw, then ack colliding with withdraw
        step(0, 0, 2, 0);
        step(0, 0, 2, 0);
        chk("t4_wd", 32'(int_req_o), 0);
        chk("t4_noclr", 32'(clr_o), 0);
        step(0, mk(1, 9, 88), 2, 0);
        step(0, mk(1, 9, 88), 2, 0);
        step(0, 0, 2, 0);
        step(0, 0, 2, 1);
        chk("t4_ackwin", 32'(clr_o), 1);
        chk("t4_clrid", 32'(clr_id_o), 24);

        // Spurious acks in ACKD and IDLE
        step(0, 0, 2, 1);
        chk("t5_ackd", 32'(clr_o), 0);
        step(0, 0, 2, 0);
        step(0, 0, 2, 1);
        chk("t5_idle", 32'(clr_o), 0);
        chk("t5_busy", 32'(busy_o), 0);

        // Reset in REQ and in ACKD
        step(0, mk(1, 9, 88), 2, 0);
        step(0, mk(1, 9, 88), 2, 0);
        step(1, mk(1, 9, 88), 2, 1);
        chk("t6_req", 32'(int_req_o), 0);
        chk("t6_clr", 32'(clr_o), 0);
        chk("t6_vec", 32'(int_vec_o), 0);
        step(0, mk(1, 9, 88), 2, 0);
        step(0, mk(1, 9, 88), 2, 0);
        step(0, mk(1, 9, 88), 2, 1);
        step(1, mk(1, 9, 88), 2, 0);
        chk("t6_busy", 32'(busy_o), 0);
        chk("t6_lvl", 32'(int_lvl_o), 0);

        // Random traffic
        s = mk(1, 6, 80);
        m = 4'd3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 30)
                s = mk($urandom_range(0, 99) < 80, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            if ($urandom_range(0, 99) < 10)
                m = 4'($urandom_range(0, 15));
            step($urandom_range(0, 199) == 0, s, m, $urandom_range(0, 99) < 20);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
